// File: rtl/dcache_if.sv
// Bus bundle for dcache_ctrl: MEM-stage request side and word-serial memory side.
//
// Handshake semantics:
//   Request side  - a request (req_rd | req_wr) is accepted on the first rising
//                   edge where dcache_stall is low. While dcache_stall is high the
//                   requester holds every req_* field stable.
//   Memory side   - mem_rd / mem_wr act as "valid" with mem_addr / mem_wdata held
//                   stable until the edge where mem_ack (the "ready") is sampled
//                   high. That edge completes one word, and mem_rdata is
//                   valid alongside mem_ack. mem_rd and mem_wr are never high
//                   together. A mem_ack with no outstanding request is ignored.
interface dcache_if #(
    parameter int ADDR_WID = 32,
    parameter int DATA_WID = 32
);
    logic [ADDR_WID-1:0]   req_addr;
    logic [DATA_WID-1:0]   req_wdata;
    logic [DATA_WID/8-1:0] req_be;
    logic                  req_rd;
    logic                  req_wr;
    logic [DATA_WID-1:0]   rdata;
    logic                  dcache_stall;
    logic [ADDR_WID-1:0]   mem_addr;
    logic [DATA_WID-1:0]   mem_wdata;
    logic                  mem_rd;
    logic                  mem_wr;
    logic                  mem_ack;
    logic [DATA_WID-1:0]   mem_rdata;

    // Cache controller side
    modport slave (
        input  req_addr, req_wdata, req_be, req_rd, req_wr, mem_ack, mem_rdata,
        output rdata, dcache_stall, mem_addr, mem_wdata, mem_rd, mem_wr
    );

    // Pipeline + memory environment side
    modport master (
        output req_addr, req_wdata, req_be, req_rd, req_wr, mem_ack, mem_rdata,
        input  rdata, dcache_stall, mem_addr, mem_wdata, mem_rd, mem_wr
    );
endinterface

// File: rtl/dcache_ctrl.sv
// Direct-mapped, write-back, write-allocate data cache controller.
// Hits complete with no added cycles; a miss optionally writes back the dirty
// victim line word by word (WB), then refills the line word by word (FILL).
// Optional feature macro: DCACHE_STATS_EN adds 32-bit wrapping stat_hits and
// stat_misses counters as extra outputs.
module dcache_ctrl #(
    parameter int ADDR_WID    = 32,
    parameter int DATA_WID    = 32,
    parameter int INDEX_BITS  = 6,
    parameter int OFFSET_BITS = 2
) (
    input  logic       clk,
    input  logic       rst,
    dcache_if.slave    bus,
    output logic [1:0] state_dbg
`ifdef DCACHE_STATS_EN
    ,
    output logic [31:0] stat_hits,
    output logic [31:0] stat_misses
`endif
);
    localparam int TAG_BITS = ADDR_WID - INDEX_BITS - OFFSET_BITS - 2;
    localparam int LINES    = 1 << INDEX_BITS;
    localparam int WORDS    = 1 << OFFSET_BITS;
    localparam int BE_W     = DATA_WID / 8;

    typedef enum logic [1:0] {S_IDLE = 2'd0, S_WB = 2'd1, S_FILL = 2'd2} state_t;

    state_t                   state_q, state_d;
    logic [OFFSET_BITS-1:0]   cnt_q;
    logic [LINES-1:0]         valid_q;
    logic [LINES-1:0]         dirty_q;
    logic [TAG_BITS-1:0]      tag_mem  [LINES];
    logic [DATA_WID-1:0]      data_mem [LINES*WORDS];

    logic                     req;
    logic [TAG_BITS-1:0]      req_tag;
    logic [INDEX_BITS-1:0]    req_idx;
    logic [OFFSET_BITS-1:0]   req_off;
    logic                     hit;
    logic                     last_word;
    logic                     store_hit;
    logic                     fill_ack;
    logic [DATA_WID-1:0]      line_word;
    logic [DATA_WID-1:0]      merged;
    logic                     unused_addr_bits;

    assign req       = bus.req_rd | bus.req_wr;
    assign req_tag   = bus.req_addr[ADDR_WID-1 -: TAG_BITS];
    assign req_idx   = bus.req_addr[OFFSET_BITS+2 +: INDEX_BITS];
    assign req_off   = bus.req_addr[2 +: OFFSET_BITS];
    assign hit       = valid_q[req_idx] && (tag_mem[req_idx] == req_tag);
    assign last_word = (cnt_q == {OFFSET_BITS{1'b1}});
    assign line_word = data_mem[{req_idx, req_off}];
    assign store_hit = (state_q == S_IDLE) && bus.req_wr && hit;
    assign fill_ack  = (state_q == S_FILL) && bus.mem_ack;
    assign state_dbg = state_q;
    // Byte offset bits never select anything: all accesses are word-wide.
    assign unused_addr_bits = ^bus.req_addr[1:0];

    // Byte-merge the store data into the currently addressed line word.
    always_comb begin
        merged = line_word;
        for (int b = 0; b < BE_W; b++) begin
            if (bus.req_be[b]) merged[8*b +: 8] = bus.req_wdata[8*b +: 8];
        end
    end

    // Next-state and bus outputs; everything forced to zero while in reset.
    always_comb begin
        state_d          = state_q;
        bus.rdata        = '0;
        bus.dcache_stall = 1'b0;
        bus.mem_rd       = 1'b0;
        bus.mem_wr       = 1'b0;
        bus.mem_addr     = '0;
        bus.mem_wdata    = '0;
        case (state_q)
            S_IDLE: begin
                if (req) begin
                    if (hit) begin
                        if (!bus.req_wr) bus.rdata = line_word;
                    end else begin
                        bus.dcache_stall = 1'b1;
                        state_d = (valid_q[req_idx] && dirty_q[req_idx]) ? S_WB : S_FILL;
                    end
                end
            end
            S_WB: begin
                bus.dcache_stall = 1'b1;
                bus.mem_wr       = 1'b1;
                bus.mem_addr     = {tag_mem[req_idx], req_idx, cnt_q, 2'b00};
                bus.mem_wdata    = data_mem[{req_idx, cnt_q}];
                if (bus.mem_ack && last_word) state_d = S_FILL;
            end
            S_FILL: begin
                bus.dcache_stall = 1'b1;
                bus.mem_rd       = 1'b1;
                bus.mem_addr     = {req_tag, req_idx, cnt_q, 2'b00};
                if (bus.mem_ack && last_word) state_d = S_IDLE;
            end
            default: state_d = S_IDLE;
        endcase
        if (rst) begin
            bus.rdata        = '0;
            bus.dcache_stall = 1'b0;
            bus.mem_rd       = 1'b0;
            bus.mem_wr       = 1'b0;
            bus.mem_addr     = '0;
            bus.mem_wdata    = '0;
        end
    end

    // State, word counter and per-line valid/dirty bits.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= S_IDLE;
            cnt_q   <= '0;
            valid_q <= '0;
            dirty_q <= '0;
        end else begin
            state_q <= state_d;
            if ((state_q == S_WB || state_q == S_FILL) && bus.mem_ack) begin
                cnt_q <= cnt_q + OFFSET_BITS'(1);
                if (last_word) begin
                    dirty_q[req_idx] <= 1'b0;
                    if (state_q == S_FILL) valid_q[req_idx] <= 1'b1;
                end
            end
            if (store_hit) dirty_q[req_idx] <= 1'b1;
        end
    end

    // Line data and tag storage: refill words and store-hit merges.
    always_ff @(posedge clk) begin
        if (!rst) begin
            if (fill_ack) begin
                data_mem[{req_idx, cnt_q}] <= bus.mem_rdata;
                if (last_word) tag_mem[req_idx] <= req_tag;
            end else if (store_hit) begin
                data_mem[{req_idx, req_off}] <= merged;
            end
        end
    end

`ifdef DCACHE_STATS_EN
    logic fill_done_q;

    // Hit/miss counters; the completion cycle right after a refill is not a hit.
    always_ff @(posedge clk) begin
        if (rst) begin
            stat_hits   <= '0;
            stat_misses <= '0;
            fill_done_q <= 1'b0;
        end else begin
            fill_done_q <= fill_ack && last_word;
            if (state_q == S_IDLE && state_d != S_IDLE) stat_misses <= stat_misses + 32'd1;
            if (state_q == S_IDLE && req && hit && !fill_done_q) stat_hits <= stat_hits + 32'd1;
        end
    end
`endif
endmodule

// File: tb/tb_dcache_ctrl.sv
// Self-checking bench for dcache_ctrl: directed loads/stores, a responding
// memory model with programmable ack latency, and a scoreboard monitor that
// compares memory transactions and load data against expected queues.
module tb_dcache_ctrl;
    localparam int AW = 32;
    localparam int DW = 32;

    // ---------------- clock / reset ----------------
    logic       clk = 1'b0;
    logic       rst = 1'b1;
    logic [1:0] state_dbg;
    always #5 clk = ~clk;

    dcache_if #(.ADDR_WID(AW), .DATA_WID(DW)) bus_if ();

`ifdef DCACHE_STATS_EN
    logic [31:0] stat_hits;
    logic [31:0] stat_misses;
`endif

    dcache_ctrl #(.ADDR_WID(AW), .DATA_WID(DW), .INDEX_BITS(6), .OFFSET_BITS(2)) dut (
        .clk       (clk),
        .rst       (rst),
        .bus       (bus_if),
        .state_dbg (state_dbg)
`ifdef DCACHE_STATS_EN
        ,
        .stat_hits   (stat_hits),
        .stat_misses (stat_misses)
`endif
    );

    // ---------------- scoreboard state ----------------
    int checks   = 0;
    int failures = 0;
    logic [64:0]   mem_exp_q[$];   // {is_write, addr, wdata}
    logic [DW-1:0] load_exp_q[$];
    logic [DW-1:0] mem_model [logic [AW-1:0]];
    int ack_delay = 0;
    int wait_cnt  = 0;

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s actual=0x%0h required=0x%0h", name, act, exp);
        end
    endtask

    task automatic push_rd_line(input logic [AW-1:0] base);
        for (int k = 0; k < 4; k++) mem_exp_q.push_back({1'b0, base + AW'(4*k), 32'h0});
    endtask

    task automatic push_wr(input logic [AW-1:0] addr, input logic [DW-1:0] data);
        mem_exp_q.push_back({1'b1, addr, data});
    endtask

    // ---------------- memory responder ----------------
    initial begin
        bus_if.mem_ack   = 1'b0;
        bus_if.mem_rdata = '0;
        forever begin
            @(posedge clk); #1;
            bus_if.mem_ack = 1'b0;
            if (rst) begin
                wait_cnt = 0;
            end else if (bus_if.mem_rd || bus_if.mem_wr) begin
                if (wait_cnt < ack_delay) begin
                    wait_cnt++;
                end else begin
                    wait_cnt = 0;
                    bus_if.mem_ack = 1'b1;
                    if (bus_if.mem_rd)
                        bus_if.mem_rdata = mem_model.exists(bus_if.mem_addr) ? mem_model[bus_if.mem_addr] : '0;
                    else
                        mem_model[bus_if.mem_addr] = bus_if.mem_wdata;
                end
            end
        end
    end

    // ---------------- monitor ----------------
    logic [AW-1:0] last_addr;
    logic          last_pending = 1'b0;
    always @(negedge clk) begin
        logic [64:0] e;
        if (rst) begin
            last_pending = 1'b0;
        end else begin
            if (bus_if.mem_rd || bus_if.mem_wr) begin
                check("mem_rd_wr_exclusive", 64'(bus_if.mem_rd & bus_if.mem_wr), 64'd0);
                check("stall_during_mem", 64'(bus_if.dcache_stall), 64'd1);
                if (last_pending) check("mem_addr_stable", 64'(bus_if.mem_addr), 64'(last_addr));
                if (bus_if.mem_ack) begin
                    last_pending = 1'b0;
                    if (mem_exp_q.size() == 0) begin
                        checks++;
                        failures++;
                        $display("FAIL mem_unexpected actual=%s@0x%0h required=none",
                                 bus_if.mem_wr ? "wr" : "rd", bus_if.mem_addr);
                    end else begin
                        e = mem_exp_q.pop_front();
                        check("mem_kind", 64'(bus_if.mem_wr), 64'(e[64]));
                        check("mem_addr", 64'(bus_if.mem_addr), 64'(e[63:32]));
                        if (e[64]) check("mem_wdata", 64'(bus_if.mem_wdata), 64'(e[31:0]));
                    end
                end else begin
                    last_pending = 1'b1;
                    last_addr    = bus_if.mem_addr;
                end
            end else begin
                last_pending = 1'b0;
            end
            if (bus_if.req_rd && !bus_if.req_wr && !bus_if.dcache_stall) begin
                if (load_exp_q.size() == 0) begin
                    checks++;
                    failures++;
                    $display("FAIL load_unexpected actual=0x%0h required=none", bus_if.rdata);
                end else begin
                    check("load_rdata", 64'(bus_if.rdata), 64'(load_exp_q.pop_front()));
                end
            end
        end
    end

    // ---------------- driver tasks ----------------
    // Called at posedge+1; holds the request until the completion edge.
    task automatic issue(input logic wr, input logic [AW-1:0] addr, input logic [DW-1:0] wdata,
                         input logic [3:0] be, input logic exp_stall);
        int n = 0;
        bus_if.req_addr  = addr;
        bus_if.req_wdata = wdata;
        bus_if.req_be    = be;
        bus_if.req_rd    = !wr;
        bus_if.req_wr    = wr;
        @(negedge clk);
        check("req_cycle_stall", 64'(bus_if.dcache_stall), 64'(exp_stall));
        while (bus_if.dcache_stall && n < 200) begin
            @(negedge clk);
            n++;
        end
        if (bus_if.dcache_stall) begin
            checks++;
            failures++;
            $display("FAIL req_timeout actual=stalled required=done addr=0x%0h", addr);
        end
        @(posedge clk); #1;
        bus_if.req_rd = 1'b0;
        bus_if.req_wr = 1'b0;
    endtask

    task automatic do_load(input logic [AW-1:0] addr, input logic [DW-1:0] exp_data, input logic exp_stall);
        load_exp_q.push_back(exp_data);
        issue(1'b0, addr, '0, 4'h0, exp_stall);
    endtask

    task automatic do_store(input logic [AW-1:0] addr, input logic [DW-1:0] wdata,
                            input logic [3:0] be, input logic exp_stall);
        issue(1'b1, addr, wdata, be, exp_stall);
    endtask

    // ---------------- directed sequence ----------------
    initial begin
        int n;
        bus_if.req_addr  = '0;
        bus_if.req_wdata = '0;
        bus_if.req_be    = '0;
        bus_if.req_rd    = 1'b0;
        bus_if.req_wr    = 1'b0;
        mem_model[32'h100] = 32'h11; mem_model[32'h104] = 32'h22;
        mem_model[32'h108] = 32'h33; mem_model[32'h10C] = 32'h44;
        mem_model[32'h200] = 32'hA0; mem_model[32'h204] = 32'hA1;
        mem_model[32'h208] = 32'hA2; mem_model[32'h20C] = 32'hA3;
        mem_model[32'h500] = 32'h55; mem_model[32'h504] = 32'h66;
        mem_model[32'h508] = 32'h77; mem_model[32'h50C] = 32'h88;

        rst = 1'b1;
        repeat (3) @(posedge clk);
        #1 rst = 1'b0;
        @(negedge clk);
        check("rst_stall",     64'(bus_if.dcache_stall), 64'd0);
        check("rst_mem_rd",    64'(bus_if.mem_rd),       64'd0);
        check("rst_mem_wr",    64'(bus_if.mem_wr),       64'd0);
        check("rst_mem_addr",  64'(bus_if.mem_addr),     64'd0);
        check("rst_mem_wdata", 64'(bus_if.mem_wdata),    64'd0);
        check("rst_rdata",     64'(bus_if.rdata),        64'd0);
        @(posedge clk); #1;

        // Cold miss then hit in the same line
        push_rd_line(32'h100);
        do_load(32'h100, 32'h11, 1'b1);
        do_load(32'h108, 32'h33, 1'b0);

        // Store hit with partial byte enables
        do_store(32'h104, 32'hDEADBEEF, 4'b0011, 1'b0);
        do_load(32'h104, 32'h0000BEEF, 1'b0);

        // Conflict miss: dirty writeback then slow refill
        ack_delay = 3;
        push_wr(32'h100, 32'h11);
        push_wr(32'h104, 32'h0000BEEF);
        push_wr(32'h108, 32'h33);
        push_wr(32'h10C, 32'h44);
        push_rd_line(32'h500);
        do_load(32'h500, 32'h55, 1'b1);
        ack_delay = 0;
        do_load(32'h50C, 32'h88, 1'b0);

        // Store miss: write-allocate then merge the top byte
        push_rd_line(32'h200);
        do_store(32'h204, 32'h12345678, 4'b1000, 1'b1);
        do_load(32'h204, 32'h120000A1, 1'b0);

        // Reset while the second refill word is outstanding
        ack_delay = 2;
        mem_exp_q.push_back({1'b0, 32'h100, 32'h0});
        bus_if.req_addr = 32'h108;
        bus_if.req_be   = 4'h0;
        bus_if.req_rd   = 1'b1;
        n = 0;
        do begin
            @(posedge clk); #1;
            n++;
        end while (!(bus_if.mem_rd && bus_if.mem_addr == 32'h104) && n < 100);
        if (n >= 100) begin
            checks++;
            failures++;
            $display("FAIL mid_fill_reach actual=not_seen required=mem_rd@0x104");
        end
        rst = 1'b1;
        bus_if.req_rd = 1'b0;
        @(posedge clk); #1;
        rst = 1'b0;
        ack_delay = 0;
        @(negedge clk);
        check("post_rst_stall",  64'(bus_if.dcache_stall), 64'd0);
        check("post_rst_mem_rd", 64'(bus_if.mem_rd),       64'd0);
        check("post_rst_mem_wr", 64'(bus_if.mem_wr),       64'd0);
`ifdef DCACHE_STATS_EN
        check("stat_hits_rst",   64'(stat_hits),   64'd0);
        check("stat_misses_rst", 64'(stat_misses), 64'd0);
`endif
        @(posedge clk); #1;

        // Line was invalidated: miss, hit, hit, miss
        push_rd_line(32'h100);
        do_load(32'h108, 32'h33, 1'b1);
        do_load(32'h108, 32'h33, 1'b0);
        do_load(32'h100, 32'h11, 1'b0);
        push_rd_line(32'h500);
        do_load(32'h500, 32'h55, 1'b1);
`ifdef DCACHE_STATS_EN
        check("stat_hits",   64'(stat_hits),   64'd2);
        check("stat_misses", 64'(stat_misses), 64'd2);
`endif

        repeat (3) @(posedge clk);
        check("mem_exp_q_empty",  64'(mem_exp_q.size()),  64'd0);
        check("load_exp_q_empty", 64'(load_exp_q.size()), 64'd0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

    // Global watchdog
    initial begin
        #200000;
        $display("FAIL watchdog actual=running required=finished");
        $fatal(1, "watchdog expired");
    end
endmodule

// File: doc/dcache_ctrl.md
Name: dcache_ctrl

Overview:
- Direct-mapped, write-back, write-allocate data cache controller between the MEM stage and the data memory.
- Generates `dcache_stall`, which freezes the upstream pipeline and bubbles MEM/WB while a miss is serviced.
- Hits complete in zero added cycles. Misses perform an optional dirty-line writeback, then a line refill over a word-serial request/ack memory port.

Parameters:
- ADDR_WID, 32, request/memory address width
- DATA_WID, 32, word width; the byte-enable is DATA_WID/8 bits
- INDEX_BITS, 6, line index width (64 lines)
- OFFSET_BITS, 2, word-in-line width (4 words per line); tag = ADDR_WID-INDEX_BITS-OFFSET_BITS-2

Ports:
- clk  in  1  clock
- rst  in  1  reset
- req_addr  in  ADDR_WID  byte address from MEM stage
- req_wdata  in  DATA_WID  store data
- req_be  in  DATA_WID/8  store byte enables
- req_rd  in  1  load request
- req_wr  in  1  store request
- rdata  out  DATA_WID  load data (combinational on hit)
- dcache_stall  out  1  high while the current request cannot complete
- mem_addr  out  ADDR_WID  word-aligned memory address
- mem_wdata  out  DATA_WID  writeback data
- mem_rd  out  1  memory read request
- mem_wr  out  1  memory write request
- mem_ack  in  1  memory accepted/completed current word
- mem_rdata  in  DATA_WID  read data, valid with mem_ack

Behaviour:
- Reset: `rst` is synchronous and active-high; clock is `clk`. On reset:
  - all valid and dirty bits clear; FSM goes to IDLE; word counter is 0.
  - rdata=0, dcache_stall=0, mem_rd=0, mem_wr=0, mem_addr=0, mem_wdata=0.
- Request fields: req = req_rd|req_wr. If both are high, it is treated as a store. Upstream holds all req_* stable while dcache_stall=1.
- Lookup (IDLE, combinational): hit = valid[idx] & tag[idx]==req tag.
  - Load hit: rdata = line word, dcache_stall=0.
  - Store hit: byte-merge req_wdata per req_be into the word at the next edge; set dirty; dcache_stall=0.
  - No request: rdata=0, stall=0.
- Miss in IDLE: dcache_stall=1 combinationally in the same cycle. Next state is WB if the line is valid & dirty, else FILL.
- WB state, for k=0..2^OFFSET_BITS-1:
  - mem_wr=1, mem_addr={old tag, idx, k, 00}, mem_wdata=line word k.
  - Address and data held stable until mem_ack; k advances on each ack.
  - After the last ack, clear dirty and go to FILL.
- FILL state, for k=0..2^OFFSET_BITS-1:
  - mem_rd=1, mem_addr={req tag, idx, k, 00}, held until mem_ack.
  - On ack, write mem_rdata to word k.
  - After the last ack, set valid, write the tag, clear dirty, go to IDLE.
- Completion: in IDLE the held request now hits and completes as above, including the store merge and dirty set.
  - Stall deasserts the cycle after the last fill ack.
  - dcache_stall=1 in every non-IDLE cycle.
- Memory handshake: mem_rd and mem_wr are never high together. mem_ack with no outstanding request is ignored. The request drops in the cycle after the final ack.
- Counter wrap: k wraps to 0 at line end.
- Reset mid-WB or mid-FILL: next cycle in IDLE with mem_rd/mem_wr=0. The partial line is invalid and dirty data is discarded.

Optional Feature:
- Macro DCACHE_STATS_EN.
- Defined: adds outputs stat_hits and stat_misses, each 32 bits, wrapping, reset to 0.
  - stat_misses increments on each IDLE→WB/FILL transition.
  - stat_hits increments on each IDLE hit cycle with a request and stall=0. The post-refill completion cycle is not counted as a hit.
- Undefined: no counters and no stat ports.

Test Plan:
- Reset, load 0x100, mem acks every cycle returning 0x11, 0x22, 0x33, 0x44:
  - stall=1 in the request cycle; mem_rd at 0x100, 0x104, 0x108, 0x10C.
  - Stall drops the cycle after the 4th ack with rdata=0x11.
  - Then load 0x108 → stall=0, rdata=0x33.
- Store 0x104, wdata=0xDEADBEEF, be=4'b0011 → stall=0. Next load 0x104 → rdata=0x0000BEEF.
- Load 0x500 (same index 0x10, different tag):
  - mem_wr at 0x100..0x10C with data 0x11, 0x0000BEEF, 0x33, 0x44.
  - Then mem_rd at 0x500..0x50C; stall high throughout.
- Delay mem_ack by 3 cycles per word during FILL → mem_rd and mem_addr remain stable and stall stays 1 until the final ack; no word skipped.
- Assert rst during the 2nd FILL word → next cycle stall=0, mem_rd=0. Re-load 0x108 misses and refills.
- With DCACHE_STATS_EN: the sequence miss, hit, hit, miss → stat_misses=2, stat_hits=2. After rst both read 0.
